// File: rtl/serv_rf_pkg.sv
// serv_rf_pkg: shared types and helpers for the SERV register-file sequencer.
//   rf_state_e - sequencer FSM states
//   READY_LAT  - request-to-ready latency in cycles
//   RAW        - register index width (6 when RF_CSR_EN is defined, else 5)
//   w_legal()  - checks the RAM data width
//   rf_aw()    - RAM address width for a given index width and RAM data width
// Optional feature macro: RF_CSR_EN (adds CSR indices 32..35).
package serv_rf_pkg;

    localparam int READY_LAT = 3;

`ifdef RF_CSR_EN
    localparam int RAW = 6;
`else
    localparam int RAW = 5;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE1,
        ST_PRE2,
        ST_PRE3,
        ST_RUN,
        ST_FLUSH
    } rf_state_e;

    function automatic bit w_legal(input int w);
        return (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
    endfunction

    function automatic int rf_aw(input int raw, input int w);
        return raw + $clog2(32 / w);
    endfunction

endpackage

// File: rtl/serv_rf_shreg.sv
// serv_rf_shreg: W-bit word serialiser/deserialiser, shifting right (LSB first).
//   i_clr   - clear word and bit count
//   i_load  - parallel load of i_din (or zero when i_zero)
//   i_shift - shift one bit, i_sin enters at the MSB
//   o_sout  - current LSB
//   o_word  - current word contents
//   o_full  - this shift completes a W-bit word
module serv_rf_shreg #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic         i_zero,
    input  logic [W-1:0] i_din,
    input  logic         i_sin,
    output logic         o_sout,
    output logic [W-1:0] o_word,
    output logic         o_full
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        o_full = 1'b0;
        if (i_clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (i_load) begin
            word_d = i_zero ? '0 : i_din;
            cnt_d  = '0;
        end else if (i_shift) begin
            word_d = {i_sin, word_q[W-1:1]};
            cnt_d  = cnt_q + CW'(1);
            o_full = (cnt_q == CW'(W - 1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_sout = word_q[0];
    assign o_word = word_q;

endmodule

// File: rtl/serv_rf_seq.sv
// serv_rf_seq: bit-serial register-file sequencer between the SERV core and a
// W-bit 1R1W synchronous RAM (read data valid one cycle after o_raddr).
//   i_rreq/i_wreq - request strobes, sampled only in IDLE
//   o_ready       - one-cycle pulse three cycles after the request
//   i_rs1/rs2/rd_addr, i_wen, i_wdata - core side, stable through the window
//   o_rs1/o_rs2   - serial read data, bit k in the k-th RUN cycle
//   o_raddr/i_rdata, o_waddr/o_wdata/o_wen - RAM side
// Optional feature macro: RF_CSR_EN (widens register index to 6 bits).
//
// state | meaning
// IDLE  | waiting for a request
// PRE1  | read rs1 word 0
// PRE2  | read rs2 word 0, capture rs1 word 0
// PRE3  | o_ready, load word 0 into both serialisers
// RUN   | 32 bit cycles, prefetch next words, collect rd bits
// FLUSH | last rd word written
module serv_rf_seq
    import serv_rf_pkg::*;
#(
    parameter  int W   = 2,
    localparam int WPR = 32 / W,
    localparam int AW  = rf_aw(RAW, W)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_rreq,
    input  logic           i_wreq,
    output logic           o_ready,
    input  logic [RAW-1:0] i_rs1_addr,
    input  logic [RAW-1:0] i_rs2_addr,
    input  logic [RAW-1:0] i_rd_addr,
    input  logic           i_wen,
    input  logic           i_wdata,
    output logic           o_rs1,
    output logic           o_rs2,
    output logic [AW-1:0]  o_raddr,
    input  logic [W-1:0]   i_rdata,
    output logic [AW-1:0]  o_waddr,
    output logic [W-1:0]   o_wdata,
    output logic           o_wen
);

    if (!w_legal(W)) begin : g_bad_w
        $error("serv_rf_seq: W must be 2, 4, 8, 16 or 32");
    end

    localparam int         LW       = $clog2(W);
    localparam logic [5:0] PH_MASK  = 6'(W - 1);
    localparam logic [5:0] WPR6     = 6'(WPR);
    localparam logic [5:0] LAST_CYC = 6'(READY_LAT + 31);

    rf_state_e      state_q, state_d;
    logic [5:0]     cyc_q, cyc_d;
    logic [W-1:0]   hold_q, hold_d;
    logic           wen_q, wen_d;
    logic [AW-1:0]  waddr_q, waddr_d;

    logic           busy, hold_en, rs_load, rs_shift, rd_shift, clr;
    logic [5:0]     ph, rword, lcyc, lword, kcyc;
    logic           rs1_sout, rs2_sout, rd_sout, rs1_full, rs2_full, rd_full;
    logic [W-1:0]   rs1_word, rs2_word, rd_word;

    function automatic logic [AW-1:0] ram_addr(input logic [RAW-1:0] idx, input logic [5:0] word);
        return AW'(idx) * AW'(WPR) + AW'(word);
    endfunction

    // cyc counts from 0 in PRE1. Word n of rs1 is read at cyc n*W, rs2 at n*W+1,
    // and both are loaded at cyc n*W+2: rs1 via the hold register, rs2 straight
    // from the RAM. This keeps the next word ready at every word boundary.
    assign busy  = (state_q != ST_IDLE) && (state_q != ST_FLUSH);
    assign ph    = cyc_q & PH_MASK;
    assign rword = cyc_q >> LW;
    assign lcyc  = cyc_q - 6'd2;
    assign lword = lcyc >> LW;
    assign kcyc  = cyc_q - 6'(READY_LAT);
    assign clr   = (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + 6'd1;
        case (state_q)
            ST_IDLE: begin
                cyc_d = '0;
                if (i_rreq || i_wreq) state_d = ST_PRE1;
            end
            ST_PRE1:  state_d = ST_PRE2;
            ST_PRE2:  state_d = ST_PRE3;
            ST_PRE3:  state_d = ST_RUN;
            ST_RUN:   if (cyc_q == LAST_CYC) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        o_raddr = '0;
        if (busy && (rword < WPR6)) begin
            if (ph == 6'd0)      o_raddr = ram_addr(i_rs1_addr, rword);
            else if (ph == 6'd1) o_raddr = ram_addr(i_rs2_addr, rword);
        end

        hold_en  = ((state_q == ST_PRE2) || (state_q == ST_RUN)) && (ph == 6'd1);
        hold_d   = hold_en ? i_rdata : hold_q;
        rs_load  = ((state_q == ST_PRE3) || (state_q == ST_RUN))
                   && ((lcyc & PH_MASK) == 6'd0) && (lword < WPR6);
        rs_shift = (state_q == ST_RUN) && !rs_load;
        rd_shift = (state_q == ST_RUN);

        wen_d   = rd_full && i_wen && (i_rd_addr != '0);
        waddr_d = rd_full ? ram_addr(i_rd_addr, kcyc >> LW) : waddr_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            hold_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            hold_q  <= hold_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
        end
    end

    serv_rf_shreg #(.W(W)) u_rs1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(clr), .i_load(rs_load),
        .i_shift(rs_shift), .i_zero(i_rs1_addr == '0), .i_din(hold_q), .i_sin(1'b0),
        .o_sout(rs1_sout), .o_word(rs1_word), .o_full(rs1_full)
    );

    serv_rf_shreg #(.W(W)) u_rs2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(clr), .i_load(rs_load),
        .i_shift(rs_shift), .i_zero(i_rs2_addr == '0), .i_din(i_rdata), .i_sin(1'b0),
        .o_sout(rs2_sout), .o_word(rs2_word), .o_full(rs2_full)
    );

    // The rd word stays put for the cycle after it fills, which is exactly
    // when o_wen is high, so it drives o_wdata directly.
    serv_rf_shreg #(.W(W)) u_rd (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(clr), .i_load(1'b0),
        .i_shift(rd_shift), .i_zero(1'b0), .i_din('0), .i_sin(i_wdata),
        .o_sout(rd_sout), .o_word(rd_word), .o_full(rd_full)
    );

    logic unused_shreg;
    assign unused_shreg = ^{rs1_word, rs2_word, rs1_full, rs2_full, rd_sout};

    assign o_ready = (state_q == ST_PRE3);
    assign o_rs1   = rs1_sout;
    assign o_rs2   = rs2_sout;
    assign o_wen   = wen_q;
    assign o_waddr = waddr_q;
    assign o_wdata = rd_word;

endmodule

// File: tb/tb_serv_rf_seq.sv
module tb_serv_rf_seq;
    import serv_rf_pkg::*;

    localparam int NI = 4;

    function automatic int w_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 4 : (i == 2) ? 8 : 32;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, rreq, wreq, wen, wdat;
    logic [RAW-1:0] a1, a2, ard;
    logic           pl_en;
    logic [RAW-1:0] pl_reg;
    logic [31:0]    pl_val;

    logic        rdy_o   [NI];
    logic        rs1_o   [NI];
    logic        rs2_o   [NI];
    logic        wen_o   [NI];
    logic [15:0] waddr_o [NI];
    logic [31:0] wdata_o [NI];

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_rd [$];
    logic [55:0] exp_wr [$];

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int WI   = (gi == 0) ? 2 : (gi == 1) ? 4 : (gi == 2) ? 8 : 32;
        localparam int WPRI = 32 / WI;
        localparam int AWI  = rf_aw(RAW, WI);

        logic [AWI-1:0] raddr, waddr;
        logic [WI-1:0]  rdata, wdata;
        logic           ready, rs1, rs2, ram_wen;
        logic [31:0]    mem [1 << RAW];
        int             rrow, rbit, wrow, wbit;

        assign rrow = int'(raddr) / WPRI;
        assign rbit = (int'(raddr) % WPRI) * WI;
        assign wrow = int'(waddr) / WPRI;
        assign wbit = (int'(waddr) % WPRI) * WI;

        serv_rf_seq #(.W(WI)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .i_wreq(wreq), .o_ready(ready),
            .i_rs1_addr(a1), .i_rs2_addr(a2), .i_rd_addr(ard), .i_wen(wen), .i_wdata(wdat),
            .o_rs1(rs1), .o_rs2(rs2), .o_raddr(raddr), .i_rdata(rdata),
            .o_waddr(waddr), .o_wdata(wdata), .o_wen(ram_wen)
        );

        always @(posedge clk) begin
            rdata <= mem[rrow][rbit +: WI];
            if (pl_en) mem[pl_reg] <= pl_val;
            else if (ram_wen) mem[wrow][wbit +: WI] <= wdata;
        end

        assign rdy_o[gi]   = ready;
        assign rs1_o[gi]   = rs1;
        assign rs2_o[gi]   = rs2;
        assign wen_o[gi]   = ram_wen;
        assign waddr_o[gi] = 16'(waddr);
        assign wdata_o[gi] = 32'(wdata);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [RAW-1:0] r, input logic [31:0] v);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_reg = r; pl_val = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One request window of 37 cycles (request cycle c=0 .. FLUSH c=36); the next
    // call starts on the following cycle, so a late return to IDLE is caught.
    task automatic run_window(input bit rq, input bit wq, input logic [RAW-1:0] r1,
                              input logic [RAW-1:0] r2, input logic [RAW-1:0] rd,
                              input bit we, input logic [31:0] wv,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input bit chk_rd, input int extra_at, input int abort_at,
                              input string tag);
        logic [31:0] g1 [NI];
        logic [31:0] g2 [NI];
        logic [39:0] rmask [NI];
        int          wcnt [NI];
        logic [55:0] ent;
        logic [63:0] er;
        bit          aborted;
        aborted = 1'b0;
        exp_rd.push_back({e1, e2});
        for (int n = 0; n < 16; n++) begin
            if (we && (rd != '0) && (4 + (n + 1) * 2 < abort_at))
                exp_wr.push_back({8'(4 + (n + 1) * 2), 16'(rd) * 16'd16 + 16'(n), 30'd0, wv[2*n +: 2]});
        end
        for (int i = 0; i < NI; i++) begin
            g1[i] = '0; g2[i] = '0; rmask[i] = '0; wcnt[i] = 0;
        end
        for (int c = 0; c < 37; c++) begin
            @(posedge clk); #1;
            if (c == abort_at) rst_n = 1'b0;
            rreq = rq && ((c == 0) || (c == extra_at));
            wreq = wq && ((c == 0) || (c == extra_at));
            a1 = r1; a2 = r2; ard = rd; wen = we;
            wdat = (c >= 4 && c < 36) ? wv[c-4] : 1'b0;
            #2;
            if (c == abort_at) begin
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("%s_abort_wen_w%0d", tag, w_of(i)), 64'(wen_o[i]), 64'd0);
                    chk($sformatf("%s_abort_rdy_w%0d", tag, w_of(i)), 64'(rdy_o[i]), 64'd0);
                end
                aborted = 1'b1;
                break;
            end
            for (int i = 0; i < NI; i++) begin
                rmask[i][c] = rdy_o[i];
                if (c >= 4 && c < 36) begin
                    g1[i][c-4] = rs1_o[i];
                    g2[i][c-4] = rs2_o[i];
                end
                if (wen_o[i]) wcnt[i]++;
            end
            if (wen_o[0]) begin
                ent = (exp_wr.size() > 0) ? exp_wr.pop_front() : '1;
                chk($sformatf("%s_wr_c%0d", tag, c), 64'({8'(c), waddr_o[0], wdata_o[0]}), 64'(ent));
            end
        end
        er = exp_rd.pop_front();
        for (int i = 0; i < NI; i++) begin
            int ew;
            ew = 0;
            for (int n = 0; n < 32 / w_of(i); n++)
                if (we && (rd != '0) && (4 + (n + 1) * w_of(i) < abort_at)) ew++;
            chk($sformatf("%s_ready_w%0d", tag, w_of(i)), 64'(rmask[i]), 64'd8);
            chk($sformatf("%s_wcnt_w%0d", tag, w_of(i)), 64'(wcnt[i]), 64'(ew));
            if (chk_rd && !aborted) begin
                chk($sformatf("%s_rs1_w%0d", tag, w_of(i)), 64'(g1[i]), 64'(er[63:32]));
                chk($sformatf("%s_rs2_w%0d", tag, w_of(i)), 64'(g2[i]), 64'(er[31:0]));
            end
        end
        chk($sformatf("%s_wr_left", tag), 64'(exp_wr.size()), 64'd0);
        exp_wr.delete();
        if (aborted) begin
            rreq = 1'b0; wreq = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rreq = 1'b0; wreq = 1'b0; wen = 1'b0; wdat = 1'b0;
        a1 = '0; a2 = '0; ard = '0; pl_en = 1'b0; pl_reg = '0; pl_val = '0;
        #2;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_ctl_w%0d", w_of(i)),
                64'({rdy_o[i], rs1_o[i], rs2_o[i], wen_o[i]}), 64'd0);
            chk($sformatf("reset_waddr_w%0d", w_of(i)), 64'(waddr_o[i]), 64'd0);
            chk($sformatf("reset_wdata_w%0d", w_of(i)), 64'(wdata_o[i]), 64'd0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        preload(RAW'(0), 32'hFFFF_FFFF);
        preload(RAW'(5), 32'hA5A5_0F0F);
        preload(RAW'(6), 32'h1234_5678);
        preload(RAW'(9), 32'h0000_00FF);

        run_window(1, 0, RAW'(5), RAW'(6), RAW'(7), 0, 32'h1357_2468,
                   32'hA5A5_0F0F, 32'h1234_5678, 1, -1, 99, "rd56");
        run_window(0, 1, RAW'(5), RAW'(6), RAW'(7), 1, 32'hDEAD_BEEF,
                   32'h0, 32'h0, 0, -1, 99, "wr7");
        run_window(1, 0, RAW'(0), RAW'(7), RAW'(0), 1, 32'h5555_5555,
                   32'h0, 32'hDEAD_BEEF, 1, -1, 99, "zero");
        run_window(1, 0, RAW'(9), RAW'(5), RAW'(9), 1, 32'hCAFE_BABE,
                   32'h0000_00FF, 32'hA5A5_0F0F, 1, -1, 99, "rw9");
        run_window(1, 0, RAW'(9), RAW'(0), RAW'(0), 0, 32'h0,
                   32'hCAFE_BABE, 32'h0, 1, 20, 99, "busy");
        // Low 10 bits match x7's current value, so words written before the
        // abort leave x7 unchanged; any later write would corrupt it.
        run_window(0, 1, RAW'(7), RAW'(9), RAW'(7), 1, 32'h0000_02EF,
                   32'h0, 32'h0, 0, -1, 15, "abort");
        run_window(1, 1, RAW'(7), RAW'(9), RAW'(0), 0, 32'h0,
                   32'hDEAD_BEEF, 32'hCAFE_BABE, 1, -1, 99, "rback");
`ifdef RF_CSR_EN
        run_window(0, 1, RAW'(33), RAW'(0), RAW'(33), 1, 32'h8000_0100,
                   32'h0, 32'h0, 0, -1, 99, "csr_wr");
        run_window(1, 0, RAW'(33), RAW'(7), RAW'(0), 0, 32'h0,
                   32'h8000_0100, 32'hDEAD_BEEF, 1, -1, 99, "csr_rd");
`endif
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
